// File: rtl/udp_tx_arb_if.sv
// Handshake bundle between the payload requesters, the frame generator and udp_tx_arb.
// The slave modport is the arbiter's view; the master modport is the requester/generator side.
interface udp_tx_arb_if;
  logic        req0;
  logic [10:0] len0;
  logic [15:0] port0;
  logic        gnt0;
  logic        req1;
  logic [10:0] len1;
  logic [15:0] port1;
  logic        gnt1;
  logic        gen_start;
  logic [10:0] gen_len;
  logic [15:0] gen_dst_port;
  logic        gen_done;
  logic        active_id;
  logic        busy;
  logic        err_timeout;

  modport master (
    output req0, len0, port0, req1, len1, port1, gen_done,
    input  gnt0, gnt1, gen_start, gen_len, gen_dst_port, active_id, busy, err_timeout
  );

  modport slave (
    input  req0, len0, port0, req1, len1, port1, gen_done,
    output gnt0, gnt1, gen_start, gen_len, gen_dst_port, active_id, busy, err_timeout
  );
endinterface

// File: rtl/udp_tx_arb.sv
// Two-requester round-robin scheduler in front of the shared Ethernet/IP/UDP frame generator.
// One frame per grant: latch length/port, pulse gen_start, wait for gen_done (or time out),
// then hold off for the inter-frame gap before arbitrating again. All outputs are registered.
module udp_tx_arb #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MIN_LEN    = 18,
  parameter int unsigned MAX_LEN    = 1472,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  udp_tx_arb_if.slave    bus_io
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam int unsigned GapW = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
  // IFG_CYCLES = 0 still spends one cycle in GAP, so the last count is 0 in that case too.
  localparam logic [GapW-1:0] GapLast = (IFG_CYCLES == 0) ? '0 : GapW'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StSend, StGap} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            gen_start_q, gen_start_d;
  logic [10:0]     gen_len_q, gen_len_d;
  logic [15:0]     gen_port_q, gen_port_d;
  logic            active_id_q, active_id_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic            any_req;
  logic            sel_id;

  // Force the requested payload length into the legal UDP range for a single frame.
  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (32'(len) < MIN_LEN) begin
      return 11'(MIN_LEN);
    end else if (32'(len) > MAX_LEN) begin
      return 11'(MAX_LEN);
    end
    return len;
  endfunction

  // Next-state and registered-output decode for the frame scheduler.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    gen_start_d = 1'b0;
    gen_len_d   = gen_len_q;
    gen_port_d  = gen_port_q;
    active_id_d = active_id_q;
    err_d       = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    any_req = bus_io.req0 | bus_io.req1;
    // On a tie the requester that was not served last wins.
    if (bus_io.req0 && bus_io.req1) begin
      sel_id = ~last_q;
    end else begin
      sel_id = bus_io.req1 & ~bus_io.req0;
    end

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          active_id_d = sel_id;
          last_d      = sel_id;
          gen_len_d   = clamp_len(sel_id ? bus_io.len1 : bus_io.len0);
          gen_port_d  = sel_id ? bus_io.port1 : bus_io.port0;
          gnt0_d      = ~sel_id;
          gnt1_d      = sel_id;
          gen_start_d = 1'b1;
          state_d     = StLaunch;
        end
      end
      StLaunch: begin
        tmo_cnt_d = '0;
        state_d   = StSend;
      end
      StSend: begin
        if (bus_io.gen_done) begin
          gap_cnt_d = '0;
          state_d   = StGap;
        end else if (tmo_cnt_q == TmoLast) begin
          // Generator never finished: abandon the frame but still honour the gap.
          err_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = StGap;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      gen_start_q <= 1'b0;
      gen_len_q   <= '0;
      gen_port_q  <= '0;
      active_id_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      gen_start_q <= gen_start_d;
      gen_len_q   <= gen_len_d;
      gen_port_q  <= gen_port_d;
      active_id_q <= active_id_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign bus_io.gnt0         = gnt0_q;
  assign bus_io.gnt1         = gnt1_q;
  assign bus_io.gen_start    = gen_start_q;
  assign bus_io.gen_len      = gen_len_q;
  assign bus_io.gen_dst_port = gen_port_q;
  assign bus_io.active_id    = active_id_q;
  assign bus_io.busy         = busy_q;
  assign bus_io.err_timeout  = err_q;

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed bench for udp_tx_arb with default parameters (IFG 12, lengths 18..1472, timeout 4096).
module tb_udp_tx_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  udp_tx_arb_if bus ();

  udp_tx_arb dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a grant edge: LAUNCH, one SEND cycle ending with gen_done, then 12 GAP.
  task automatic finish_frame();
    tick();
    bus.gen_done = 1'b1;
    tick();
    bus.gen_done = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.gen_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic [10:0] clamp_in  [5];
    logic [10:0] clamp_exp [5];
    bit          ok;
    int          prev_cyc;

    clamp_in  = '{11'd0, 11'd17, 11'd18, 11'd2000, 11'd1472};
    clamp_exp = '{11'd18, 11'd18, 11'd18, 11'd1472, 11'd1472};
    checks = 0;
    errors = 0;
    cyc    = 0;
    prev_cyc = 0;

    rst_n        = 1'b0;
    bus.req0     = 1'b0;
    bus.len0     = '0;
    bus.port0    = '0;
    bus.req1     = 1'b0;
    bus.len1     = '0;
    bus.port1    = '0;
    bus.gen_done = 1'b0;

    // Reset state
    #12;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_gen_start", bus.gen_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_gen_len", bus.gen_len, 0);
    chk("rst_port", bus.gen_dst_port, 0);
    chk("rst_active_id", bus.active_id, 0);
    #10 rst_n = 1'b1;
    tick();

    // Single request from requester 0
    bus.req0  = 1'b1;
    bus.len0  = 11'd100;
    bus.port0 = 16'hC360;
    tick();
    chk("single_gnt0", bus.gnt0, 1);
    chk("single_gnt1", bus.gnt1, 0);
    chk("single_start", bus.gen_start, 1);
    chk("single_len", bus.gen_len, 100);
    chk("single_port", bus.gen_dst_port, 16'hC360);
    chk("single_id", bus.active_id, 0);
    chk("single_busy", bus.busy, 1);
    bus.req0 = 1'b0;
    tick();
    chk("launch_gnt0_clr", bus.gnt0, 0);
    chk("launch_start_clr", bus.gen_start, 0);
    chk("launch_busy", bus.busy, 1);
    bus.gen_done = 1'b1;
    tick();
    bus.gen_done = 1'b0;

    // IFG: gen_done sampled at edge T, req1 pending; gnt1 may only appear at T+13
    bus.req1  = 1'b1;
    bus.len1  = 11'd0;
    bus.port1 = 16'h1234;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("ifg_no_gnt1", bus.gnt1, 0);
      chk("ifg_busy", bus.busy, (k < 12) ? 1 : 0);
    end
    chk("ifg_len_hold", bus.gen_len, 100);
    chk("ifg_port_hold", bus.gen_dst_port, 16'hC360);
    tick();
    chk("ifg_gnt1", bus.gnt1, 1);
    chk("ifg_gnt0", bus.gnt0, 0);
    chk("ifg_start", bus.gen_start, 1);
    chk("ifg_len_clamp0", bus.gen_len, 18);
    chk("ifg_port", bus.gen_dst_port, 16'h1234);
    chk("ifg_id", bus.active_id, 1);
    bus.req1 = 1'b0;

    // gen_done during LAUNCH must be ignored; frame ends on the later SEND pulse
    bus.gen_done = 1'b1;
    tick();
    bus.gen_done = 1'b0;
    tick();
    chk("launch_done_ignored_err", bus.err_timeout, 0);
    bus.gen_done = 1'b1;
    tick();
    bus.gen_done = 1'b0;
    repeat (11) tick();
    chk("launch_done_ignored_busy", bus.busy, 1);
    tick();
    chk("gap_exit_busy", bus.busy, 0);

    // Length clamps through requester 1
    for (int i = 0; i < 5; i++) begin
      bus.req1 = 1'b1;
      bus.len1 = clamp_in[i];
      tick();
      chk("clamp_gnt1", bus.gnt1, 1);
      chk("clamp_len", bus.gen_len, clamp_exp[i]);
      bus.req1 = 1'b0;
      finish_frame();
      chk("clamp_idle", bus.busy, 0);
    end

    // Contention: both held, generator answers 80 cycles after start
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.len0  = 11'd200;
    bus.len1  = 11'd300;
    for (int i = 0; i < 4; i++) begin
      wait_start(ok);
      chk("cont_start_seen", ok, 1);
      chk("cont_id", bus.active_id, i % 2);
      chk("cont_gnt0", bus.gnt0, (i % 2 == 0) ? 1 : 0);
      chk("cont_gnt1", bus.gnt1, (i % 2 == 1) ? 1 : 0);
      chk("cont_len", bus.gen_len, (i % 2 == 0) ? 200 : 300);
      if (i > 0) chk("cont_spacing", cyc - prev_cyc, 94);
      prev_cyc = cyc;
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      repeat (80) tick();
      bus.gen_done = 1'b1;
      tick();
      bus.gen_done = 1'b0;
    end
    repeat (12) tick();
    chk("cont_idle", bus.busy, 0);

    // Timeout: req0 served, no gen_done; err pulse 4096 clocks after LAUNCH
    bus.req0  = 1'b1;
    bus.len0  = 11'd500;
    bus.port0 = 16'h0BB8;
    tick();
    chk("tmo_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    tick();
    repeat (4095) tick();
    chk("tmo_err_early", bus.err_timeout, 0);
    chk("tmo_busy", bus.busy, 1);
    tick();
    chk("tmo_err_pulse", bus.err_timeout, 1);
    tick();
    chk("tmo_err_clear", bus.err_timeout, 0);
    repeat (10) tick();
    chk("tmo_gap_busy", bus.busy, 1);
    tick();
    chk("tmo_gap_done", bus.busy, 0);

    // Next request after timeout served normally (last = 0, so req1 alone)
    bus.req1  = 1'b1;
    bus.len1  = 11'd300;
    bus.port1 = 16'hABCD;
    tick();
    chk("post_tmo_gnt1", bus.gnt1, 1);
    chk("post_tmo_len", bus.gen_len, 300);
    chk("post_tmo_id", bus.active_id, 1);
    bus.req1 = 1'b0;
    tick();
    repeat (3) tick();

    // Reset mid-SEND: outputs clear without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_len", bus.gen_len, 0);
    chk("mid_rst_port", bus.gen_dst_port, 0);
    chk("mid_rst_id", bus.active_id, 0);
    chk("mid_rst_gnt1", bus.gnt1, 0);
    #3 rst_n = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    chk("post_rst_gnt0", bus.gnt0, 1);
    chk("post_rst_gnt1", bus.gnt1, 0);
    chk("post_rst_id", bus.active_id, 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
